// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - shared types and constants for the DSP48A1 MAC controller
//
// Purpose: FSM state encoding, slice OPMODE values and the controller's
// pipeline depth. Imported by the controller, its valid pipe and the bench.
// Ports: none (package).
package dsp48a1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // OPMODE: X mux = M (bits 1:0 = 01), Z mux = 0 or P (bits 3:2 = 00 / 10).
  localparam logic [7:0] OPM_MUL = 8'h01;  // P = M
  localparam logic [7:0] OPM_MAC = 8'h09;  // P = P + M

  // Operand handshake to valid P output: A1/B1 reg, M reg, P reg.
  localparam int MAC_LAT = 3;

endpackage

// File: rtl/dsp48a1_mac_ctrl_if.sv
// rtl/dsp48a1_mac_ctrl_if.sv - job, operand and result handshakes of the MAC controller
//
// Purpose: bundles the three valid/ready channels of dsp48a1_mac_ctrl.
// Ports (signals):
//   start_valid/start_ready/start_len  job request, start_len operand pairs
//   op_valid/op_ready/op_a/op_b        18-bit signed operand pair stream
//   res_valid/res_ready/res_data       48-bit accumulated result
// Modports: master drives requests and operands, slave is the controller.
interface dsp48a1_mac_ctrl_if #(
  parameter int LEN_W = 10
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             op_valid;
  logic             op_ready;
  logic [17:0]      op_a;
  logic [17:0]      op_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  modport master (
    output start_valid, start_len, op_valid, op_a, op_b, res_ready,
    input  start_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  start_valid, start_len, op_valid, op_a, op_b, res_ready,
    output start_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp48a1_valid_pipe.sv
// rtl/dsp48a1_valid_pipe.sv - element valid pipeline generating the slice clock enables
//
// Purpose: tracks which slice stage holds a live element so that bubbles in
// the operand stream leave the slice registers untouched.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid          operand handshake this cycle (A1/B1 load)
//   in_first          the handshaking element is the first of its job
//   cem, ceopmode     element in the M / OPMODE register stage
//   mul_sel           that element is first: load OPM_MUL instead of OPM_MAC
//   cep               element in the P register stage
//   p_valid           P register holds the element's result
module dsp48a1_valid_pipe
  import dsp48a1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_first,
  output logic cem,
  output logic ceopmode,
  output logic mul_sel,
  output logic cep,
  output logic p_valid
);

  logic [MAC_LAT-1:0] vld;
  // The first flag is only consumed where OPMODE is loaded, so it is
  // carried one stage alongside the valid bit.
  logic               first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      first_q <= 1'b0;
    end else begin
      vld     <= {vld[MAC_LAT-2:0], in_valid};
      first_q <= in_valid && in_first;
    end
  end

  assign cem      = vld[0];
  assign ceopmode = vld[0];
  assign mul_sel  = first_q;
  assign cep      = vld[MAC_LAT-2];
  assign p_valid  = vld[MAC_LAT-1];

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// rtl/dsp48a1_mac_ctrl.sv - dot-product job controller for one DSP48A1 slice
//
// Purpose: accepts a job of start_len operand pairs, streams them into a
// DSP48A1 (A1REG/B1REG/MREG/OPMODEREG/PREG = 1) and returns sum(a*b) mod 2^48.
// Ports:
//   CLK, RST                           clock, synchronous active-high reset
//   bus (slave)                        start / op / res handshakes
//   dsp_a, dsp_b                       slice A and B inputs
//   dsp_opmode                         slice OPMODE input
//   dsp_cea/ceb/cem/ceopmode/cep       slice clock enables
//   dsp_p                              slice P output
module dsp48a1_mac_ctrl
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  dsp48a1_mac_ctrl_if.slave bus,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_ceopmode,
  output logic              dsp_cep,
  input  logic [47:0]       dsp_p
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             first_pending;
  logic [47:0]      res_q;

  logic op_fire;
  logic cem;
  logic ceopmode;
  logic mul_sel;
  logic cep;
  logic p_valid;

  // Ready/valid are gated by RST so they read 0 while reset is held.
  assign bus.start_ready = (state == IDLE)   && !RST;
  assign bus.op_ready    = (state == STREAM) && !RST;
  assign bus.res_valid   = (state == DONE)   && !RST;
  assign op_fire         = bus.op_valid && bus.op_ready;

  // P of the last element becomes valid in the first DONE cycle; present it
  // directly then and serve the captured copy for the rest of DONE.
  assign bus.res_data = (bus.res_valid && p_valid) ? dsp_p : res_q;

  dsp48a1_valid_pipe u_valid_pipe (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (op_fire),
    .in_first (first_pending),
    .cem      (cem),
    .ceopmode (ceopmode),
    .mul_sel  (mul_sel),
    .cep      (cep),
    .p_valid  (p_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      first_pending <= 1'b0;
      res_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            if (bus.start_len != '0) begin
              cnt           <= bus.start_len;
              first_pending <= 1'b1;
              state         <= STREAM;
            end else begin
              res_q <= '0;
              state <= DONE;
            end
          end
        end
        STREAM: begin
          if (bus.op_valid) begin
            cnt           <= cnt - LEN_W'(1);
            first_pending <= 1'b0;
            if (cnt == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Only the tail of the job is in flight here; once the last
          // element sits in the P stage alone, P is valid next cycle.
          if (cep && !cem) state <= DONE;
        end
        DONE: begin
          if (p_valid) res_q <= dsp_p;
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dsp_a        = '0;
    dsp_b        = '0;
    dsp_opmode   = 8'h00;
    dsp_cea      = op_fire;
    dsp_ceb      = op_fire;
    dsp_cem      = cem;
    dsp_ceopmode = ceopmode;
    dsp_cep      = cep;
    if (op_fire) begin
      dsp_a = bus.op_a;
      dsp_b = bus.op_b;
    end
    // The first element overwrites P, so stale slice contents never leak.
    if (ceopmode) dsp_opmode = mul_sel ? OPM_MUL : OPM_MAC;
  end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb/tb_dsp48a1_mac_ctrl.sv - self-checking bench for dsp48a1_mac_ctrl with a DSP48A1 slice model
module tb_dsp48a1_mac_ctrl;
  localparam int LEN_W = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dsp48a1_mac_ctrl_if #(.LEN_W(LEN_W)) bus ();

  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep;

  // DSP48A1 slice: A1/B1, M, OPMODE and P registers, never reset.
  logic signed [17:0] a1_r, b1_r;
  logic signed [35:0] m_r;
  logic [7:0]         opm_r;
  logic [47:0]        p_r;

  dsp48a1_mac_ctrl #(.LEN_W(LEN_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_cea      (dsp_cea),
    .dsp_ceb      (dsp_ceb),
    .dsp_cem      (dsp_cem),
    .dsp_ceopmode (dsp_ceopmode),
    .dsp_cep      (dsp_cep),
    .dsp_p        (p_r)
  );

  always @(posedge CLK) begin
    if (dsp_cea) a1_r <= dsp_a;
    if (dsp_ceb) b1_r <= dsp_b;
    if (dsp_cem) m_r <= a1_r * b1_r;
    if (dsp_ceopmode) opm_r <= dsp_opmode;
    if (dsp_cep)
      p_r <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0) +
             ((opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0);
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cea = 0, n_ceb = 0, n_cem = 0, n_ceo = 0, n_cep = 0;
  always @(negedge CLK) begin
    #2;
    if (dsp_cea) n_cea++;
    if (dsp_ceb) n_ceb++;
    if (dsp_cem) n_cem++;
    if (dsp_ceopmode) n_ceo++;
    if (dsp_cep) n_cep++;
  end

  int checks = 0;
  int errors = 0;
  int last_start = 0;
  int qa[$], qb[$], qg[$];

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic push(input int a, input int b, input int g);
    qa.push_back(a);
    qb.push_back(b);
    qg.push_back(g);
  endtask

  task automatic qclear();
    qa.delete();
    qb.delete();
    qg.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, bus.start_ready, 0);
    chk({tag, "_op_ready"}, bus.op_ready, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_opmode"}, dsp_opmode, 0);
    chk({tag, "_ce"}, {dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep}, 0);
    chk({tag, "_dsp_ab"}, {dsp_a, dsp_b}, 0);
  endtask

  // All tasks are entered just after a falling edge and return on one.
  task automatic start_job(input int len, output int hs);
    bus.start_valid = 1'b1;
    bus.start_len   = LEN_W'(len);
    hs = -1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      #1;
      if (bus.start_ready) hs = cyc;
      @(negedge CLK);
    end
    bus.start_valid = 1'b0;
    chk("start_accept", (hs >= 0), 1);
  endtask

  task automatic send_op(input int a, input int b, output int hs);
    bus.op_valid = 1'b1;
    bus.op_a     = 18'(a);
    bus.op_b     = 18'(b);
    hs = -1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      #1;
      if (bus.op_ready) begin
        hs = cyc;
        chk("op_ce_ab", {dsp_cea, dsp_ceb}, 2'b11);
        chk("op_dsp_ab", {dsp_a, dsp_b}, {18'(a), 18'(b)});
      end
      @(negedge CLK);
    end
    bus.op_valid = 1'b0;
    chk("op_accept", (hs >= 0), 1);
  endtask

  task automatic wait_res(input string tag, input longint exp, input int exp_cyc, output int seen);
    seen = -1;
    for (int i = 0; i < 30 && seen < 0; i++) begin
      #1;
      if (bus.res_valid) begin
        seen = cyc;
        chk(tag, bus.res_data, exp[47:0]);
      end
      @(negedge CLK);
    end
    chk({tag, "_latency"}, seen, exp_cyc);
  endtask

  task automatic run_job(input string tag, output longint acc, output int rc);
    int n, shs, hs;
    int c_a, c_b, c_m, c_o, c_p;
    acc = 0;
    n = qa.size();
    c_a = n_cea; c_b = n_ceb; c_m = n_cem; c_o = n_ceo; c_p = n_cep;
    start_job(n, shs);
    last_start = shs;
    hs = shs - 2;  // empty job: result one cycle after the start handshake
    for (int i = 0; i < n; i++) begin
      send_op(qa[i], qb[i], hs);
      acc += longint'(qa[i]) * longint'(qb[i]);
      for (int g = 0; g < qg[i]; g++) begin
        #1;
        chk("gap_ce", {dsp_cea, dsp_ceb}, 2'b00);
        @(negedge CLK);
      end
    end
    wait_res(tag, acc, hs + 3, rc);
    chk({tag, "_n_cea"}, n_cea - c_a, n);
    chk({tag, "_n_ceb"}, n_ceb - c_b, n);
    chk({tag, "_n_cem"}, n_cem - c_m, n);
    chk({tag, "_n_ceopmode"}, n_ceo - c_o, n);
    chk({tag, "_n_cep"}, n_cep - c_p, n);
  endtask

  initial begin
    longint e;
    int rc, rc1, shs, hs;
    bus.start_valid = 1'b0;
    bus.start_len   = '0;
    bus.op_valid    = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.res_ready   = 1'b1;

    repeat (3) @(negedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b0;
    #1;
    chk("start_ready_after_reset", bus.start_ready, 1);
    @(negedge CLK);

    qclear();
    push(1, 2, 0); push(3, 4, 0); push(5, 6, 0); push(7, 8, 0);
    run_job("len4_b2b", e, rc);

    qclear();
    push(-2, 5, 2); push(131071, 2, 0); push(0, 9, 0);
    run_job("len3_gap", e, rc);

    qclear();
    run_job("len0", e, rc);

    // Result held in DONE while the consumer stalls; starts are ignored.
    bus.res_ready = 1'b0;
    qclear();
    push(rnd18(), rnd18(), 0); push(rnd18(), rnd18(), 1);
    run_job("len2_stall", e, rc);
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = i[0];
      bus.start_len   = LEN_W'(3);
      #1;
      chk("stall_res_data", bus.res_data, e[47:0]);
      chk("stall_res_valid", bus.res_valid, 1);
      chk("stall_start_ready", bus.start_ready, 0);
      @(negedge CLK);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    #1;
    chk("stall_res_data_hs", bus.res_data, e[47:0]);
    @(negedge CLK);
    #1;
    chk("after_hs_idle", {bus.res_valid, bus.start_ready, bus.op_ready}, 3'b010);
    @(negedge CLK);

    // Abort a job with reset after two of five operands.
    start_job(5, shs);
    send_op(1, 2, hs);
    send_op(3, 4, hs);
    RST          = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_a     = 18'd12345;
    bus.op_b     = 18'd3;
    @(negedge CLK);
    #1;
    chk_reset_outputs("midjob_reset");
    @(negedge CLK);
    RST          = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("start_ready_after_abort", bus.start_ready, 1);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("no_result_after_abort", bus.res_valid, 0);
      @(negedge CLK);
    end
    qclear();
    push(10, 10, 0);
    run_job("after_abort", e, rc);

    qclear();
    push(-131072, -131072, 0);
    run_job("b2b_job1", e, rc1);
    qclear();
    push(1, 1, 0);
    run_job("b2b_job2", e, rc);
    chk("b2b_start_cycle", last_start, rc1 + 1);

    for (int j = 0; j < 6; j++) begin
      int n;
      qclear();
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) push(rnd18(), rnd18(), int'($urandom_range(0, 2)));
      run_job("random_job", e, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp48a1_mac_ctrl.md
DSP48A1_MAC_CTRL -- requirements
Module: dsp48a1_mac_ctrl

Interface
REQ-001 Parameter LEN_W, default 10: width of the dot-product length field.
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 start_valid / start_ready  input / output  1 / 1  job-request handshake.
REQ-005 start_len  input  LEN_W  number of operand pairs in the job (0..2^LEN_W-1).
REQ-006 op_valid / op_ready  input / output  1 / 1  operand-stream handshake.
REQ-007 op_a, op_b  input  18 / 18  operand pair.
REQ-008 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-009 res_data  output  48  accumulated result.
REQ-010 dsp_a, dsp_b  output  18 / 18  slice A and B inputs.
REQ-011 dsp_opmode  output  8  slice OPMODE.
REQ-012 dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep  output  1 each  slice clock enables.
REQ-013 dsp_p  input  48  slice P output.

Function
REQ-014 The block SHALL drive one DSP48A1 configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, OPMODEREG=1, PREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5", and SHALL compute sum(op_a*op_b) modulo 2^48.
REQ-015 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-016 IDLE: start_ready=1. A start handshake with start_len>0 SHALL load the element counter and go to STREAM. With start_len=0 it SHALL go to DONE with res_data=0.
REQ-017 STREAM: op_ready=1. Each op handshake SHALL decrement the counter. The handshake that takes the counter to 0 SHALL move the FSM to DRAIN.
REQ-018 For an op handshake in cycle t, the block SHALL:
- in cycle t: drive dsp_a=op_a, dsp_b=op_b, dsp_cea=dsp_ceb=1;
- in cycle t+1: drive dsp_cem=1 and dsp_ceopmode=1;
- in cycle t+2: drive dsp_cep=1.
REQ-019 dsp_opmode in cycle t+1 SHALL be 8'h01 (P=M) for the first element of a job and 8'h09 (P=P+M) for every later element.
REQ-020 All CE outputs SHALL be 0 in cycles with no element at that stage, so that op_valid bubbles hold the pipeline.
REQ-021 DRAIN SHALL last until the last element's cep cycle has completed. The block SHALL then capture dsp_p into res_data and enter DONE. Resulting latency: last op handshake at t -> res_valid=1 at t+3.
REQ-022 DONE: res_valid=1 and res_data SHALL be held stable until res_ready. After the handshake the FSM SHALL return to IDLE.
REQ-023 start_ready=0 outside IDLE; start_valid outside IDLE SHALL be ignored.
REQ-024 op_ready=0 outside STREAM; op data outside STREAM SHALL be ignored.
REQ-025 A new job SHALL be acceptable in the cycle after the res handshake.
REQ-026 Accumulation overflow SHALL wrap silently with no flag.

Reset
REQ-027 RST SHALL force IDLE and clear the counter and the internal valid pipeline.
REQ-028 During RST: start_ready=0, op_ready=0, res_valid=0, res_data=0, dsp_opmode=8'h00, all dsp_ce*=0, dsp_a=dsp_b=0. start_ready SHALL become 1 in the first cycle after RST deasserts.
REQ-029 RST mid-job SHALL abort the job with no result produced. The next job SHALL produce a correct sum regardless of stale slice contents, because its first element uses OPMODE 8'h01.

Structure
REQ-030 The following SHALL live in shared package dsp48a1_pkg:
- FSM state enum;
- OPMODE constants OPM_MUL=8'h01 and OPM_MAC=8'h09;
- pipeline depth constant MAC_LAT=3.
REQ-031 One sub-module SHALL exist: dsp48a1_valid_pipe, a MAC_LAT-deep shift register of {valid, first} bits that generates cem, ceopmode, cep and the opmode select.

Verification
REQ-032 len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, res_ready=1 -> res_data=100; res_valid exactly 3 cycles after the last op handshake.
REQ-033 len=3, (-2,5),(131071,2),(0,9) with a 2-cycle op_valid gap after the first pair -> res_data=262132; CE outputs 0 during the gap.
REQ-034 len=0 -> res_valid the cycle after start with res_data=0; no dsp_ce* asserted.
REQ-035 len=2 with res_ready held 0 for 5 cycles in DONE -> res_data stable and start_ready=0 throughout; start_valid pulses ignored.
REQ-036 RST after 2 of 5 operands, then new job len=1 with (10,10) -> res_data=100.
REQ-037 len=1 with (-131072,-131072), then len=1 with (1,1) in back-to-back jobs -> results 17179869184 then 1.
